// File: rtl/move_sequencer_if.sv
// Bundle of the move request, board RAM and checkDistance signals around move_sequencer.
// The sequencer is the slave side; the requester/board/checker environment is the master side.
interface move_sequencer_if;
    logic       moveValid;
    logic       moveReady;
    logic [5:0] fromPos;
    logic [5:0] toPos;
    logic [5:0] boardAddr;
    logic [3:0] boardData;
    logic       boardWe;
    logic [5:0] boardWAddr;
    logic [3:0] boardWData;
    logic [5:0] currentPosition;
    logic [5:0] targetPosition;
    logic [3:0] currentPiece;
    logic [3:0] targetPiece;
    logic       allowDistance;
    logic       doneValid;
    logic       doneOk;
    logic [2:0] doneCode;
    logic       blackToMove;
    logic [7:0] moveCount;

    modport slave (
        input  moveValid, fromPos, toPos, boardData, allowDistance,
        output moveReady, boardAddr, boardWe, boardWAddr, boardWData,
               currentPosition, targetPosition, currentPiece, targetPiece,
               doneValid, doneOk, doneCode, blackToMove, moveCount
    );

    modport master (
        output moveValid, fromPos, toPos, boardData, allowDistance,
        input  moveReady, boardAddr, boardWe, boardWAddr, boardWData,
               currentPosition, targetPosition, currentPiece, targetPiece,
               doneValid, doneOk, doneCode, blackToMove, moveCount
    );
endinterface

// File: rtl/move_sequencer.sv
// Sequences one chess move: reads both squares, waits on checkDistance, applies the
// turn/ownership/emptiness rules, then commits the move to the board or rejects it.
module move_sequencer #(
    parameter int unsigned CHECK_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    move_sequencer_if.slave bus
);
    localparam logic [3:0] LatCnt = 4'(CHECK_LAT);

    typedef enum logic [2:0] {
        StIdle, StRdFrom, StRdTo, StCapt, StCheck, StWrTo, StWrFrom, StDone
    } state_e;

    state_e     state_q;
    logic [5:0] from_q, to_q;
    logic [3:0] from_piece_q;
    logic [3:0] cnt_q;
    logic       ready_q;
    logic [5:0] addr_q;
    logic       we_q;
    logic [5:0] waddr_q;
    logic [3:0] wdata_q;
    logic [5:0] cur_pos_q, tgt_pos_q;
    logic [3:0] cur_piece_q, tgt_piece_q;
    logic       done_valid_q, done_ok_q;
    logic [2:0] done_code_q;
    logic       black_q;
    logic [7:0] count_q;

    // Type 7 is treated exactly like an empty square.
    logic       src_empty, tgt_empty;
    logic [2:0] rule_code;

    assign src_empty = (cur_piece_q[2:0] == 3'd0) || (cur_piece_q[2:0] == 3'd7);
    assign tgt_empty = (tgt_piece_q[2:0] == 3'd0) || (tgt_piece_q[2:0] == 3'd7);

    always_comb begin
        rule_code = 3'd0;
        if (cur_pos_q == tgt_pos_q) begin
            rule_code = 3'd1;
        end else if (src_empty) begin
            rule_code = 3'd2;
        end else if (cur_piece_q[3] != black_q) begin
            rule_code = 3'd3;
        end else if (!tgt_empty && (tgt_piece_q[3] == cur_piece_q[3])) begin
            rule_code = 3'd4;
        end else if (!bus.allowDistance) begin
            rule_code = 3'd5;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            from_q       <= 6'd0;
            to_q         <= 6'd0;
            from_piece_q <= 4'd0;
            cnt_q        <= 4'd0;
            ready_q      <= 1'b1;
            addr_q       <= 6'd0;
            we_q         <= 1'b0;
            waddr_q      <= 6'd0;
            wdata_q      <= 4'd0;
            cur_pos_q    <= 6'd0;
            tgt_pos_q    <= 6'd0;
            cur_piece_q  <= 4'd0;
            tgt_piece_q  <= 4'd0;
            done_valid_q <= 1'b0;
            done_ok_q    <= 1'b0;
            done_code_q  <= 3'd0;
            black_q      <= 1'b0;
            count_q      <= 8'd0;
        end else begin
            we_q         <= 1'b0;
            done_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.moveValid) begin
                        from_q  <= bus.fromPos;
                        to_q    <= bus.toPos;
                        addr_q  <= bus.fromPos;
                        ready_q <= 1'b0;
                        state_q <= StRdFrom;
                    end
                end
                StRdFrom: begin
                    addr_q  <= to_q;
                    state_q <= StRdTo;
                end
                StRdTo: begin
                    from_piece_q <= bus.boardData;
                    state_q      <= StCapt;
                end
                StCapt: begin
                    cur_pos_q   <= from_q;
                    tgt_pos_q   <= to_q;
                    cur_piece_q <= from_piece_q;
                    tgt_piece_q <= bus.boardData;
                    cnt_q       <= 4'd0;
                    state_q     <= StCheck;
                end
                StCheck: begin
                    cnt_q <= cnt_q + 4'd1;
                    // The checker inputs have now been stable for CHECK_LAT cycles.
                    if (cnt_q + 4'd1 == LatCnt) begin
                        done_code_q <= rule_code;
                        done_ok_q   <= (rule_code == 3'd0);
                        if (rule_code == 3'd0) begin
                            we_q    <= 1'b1;
                            waddr_q <= to_q;
                            wdata_q <= from_piece_q;
                            state_q <= StWrTo;
                        end else begin
                            done_valid_q <= 1'b1;
                            state_q      <= StDone;
                        end
                    end
                end
                StWrTo: begin
                    we_q    <= 1'b1;
                    waddr_q <= from_q;
                    wdata_q <= 4'd0;
                    state_q <= StWrFrom;
                end
                StWrFrom: begin
                    done_valid_q <= 1'b1;
                    state_q      <= StDone;
                end
                StDone: begin
                    if (done_ok_q) begin
                        black_q <= ~black_q;
                        if (count_q != 8'hFF) begin
                            count_q <= count_q + 8'd1;
                        end
                    end
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.moveReady       = ready_q;
    assign bus.boardAddr       = addr_q;
    assign bus.boardWe         = we_q;
    assign bus.boardWAddr      = waddr_q;
    assign bus.boardWData      = wdata_q;
    assign bus.currentPosition = cur_pos_q;
    assign bus.targetPosition  = tgt_pos_q;
    assign bus.currentPiece    = cur_piece_q;
    assign bus.targetPiece     = tgt_piece_q;
    assign bus.doneValid       = done_valid_q;
    assign bus.doneOk          = done_ok_q;
    assign bus.doneCode        = done_code_q;
    assign bus.blackToMove     = black_q;
    assign bus.moveCount       = count_q;
endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: board RAM model, directed move table, reset abort,
// randomized moves against a rule-level reference model, and move counter saturation.
module tb_move_sequencer;
    localparam int Lat = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    move_sequencer_if bus ();
    move_sequencer #(.CHECK_LAT(Lat)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Board RAM with synchronous read plus a bench-side write port for setup.
    logic [3:0] mem [64];
    logic       tb_we, tb_clr;
    logic [5:0] tb_wa;
    logic [3:0] tb_wd;
    logic [5:0] wr_a [$];
    logic [3:0] wr_d [$];

    always @(posedge clk) begin
        bus.boardData <= mem[bus.boardAddr];
        if (tb_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 4'h0;
        end else if (bus.boardWe) begin
            mem[bus.boardWAddr] <= bus.boardWData;
        end else if (tb_we) begin
            mem[tb_wa] <= tb_wd;
        end
        if (bus.boardWe) begin
            wr_a.push_back(bus.boardWAddr);
            wr_d.push_back(bus.boardWData);
        end
    end

    // Reference model state
    logic [3:0] ref_board [64];
    bit         ref_black;
    int         ref_count;
    int         n_cmp;
    int         n_bad;

    typedef struct packed {
        logic       set_en;
        logic [5:0] set_sq;
        logic [3:0] set_pc;
        logic [5:0] f;
        logic [5:0] t;
        logic       ad;
        logic [2:0] code;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic poke(input logic [5:0] sq, input logic [3:0] pc);
        tb_wa = sq;
        tb_wd = pc;
        tb_we = 1'b1;
        @(posedge clk);
        #1;
        tb_we = 1'b0;
        ref_board[sq] = pc;
    endtask

    function automatic bit is_void(input logic [3:0] pc);
        return (pc[2:0] == 3'd0) || (pc[2:0] == 3'd7);
    endfunction

    function automatic logic [2:0] ref_code(input logic [5:0] f, input logic [5:0] t, input bit ad);
        logic [3:0] sp;
        logic [3:0] tp;
        sp = ref_board[f];
        tp = ref_board[t];
        if (f == t) return 3'd1;
        if (is_void(sp)) return 3'd2;
        if (sp[3] != ref_black) return 3'd3;
        if (!is_void(tp) && (tp[3] == sp[3])) return 3'd4;
        if (!ad) return 3'd5;
        return 3'd0;
    endfunction

    function automatic logic [51:0] out_vec();
        return {bus.moveReady, bus.boardWe, bus.doneValid, bus.doneOk, bus.doneCode,
                bus.blackToMove, bus.moveCount, bus.boardAddr, bus.boardWAddr, bus.boardWData,
                bus.currentPosition, bus.targetPosition, bus.currentPiece, bus.targetPiece};
    endfunction

    task automatic do_move(input logic [5:0] f, input logic [5:0] t, input bit ad,
                           input logic [2:0] exp_code);
        int k, n, base, exp_lat;
        bit seen;
        logic [3:0] sp, tp;
        sp = ref_board[f];
        tp = ref_board[t];
        n = 0;
        while (bus.moveReady !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ready_before_accept", 64'(bus.moveReady), 64'd1);
        base = wr_a.size();
        bus.fromPos = f;
        bus.toPos = t;
        bus.allowDistance = ad;
        bus.moveValid = 1'b1;
        @(posedge clk);
        #1;
        bus.moveValid = 1'b0;
        chk("ready_after_accept", 64'(bus.moveReady), 64'd0);
        exp_lat = (exp_code == 3'd0) ? 5 + Lat : 3 + Lat;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (k >= 3 && k <= 2 + Lat) begin
                chk("check_inputs_held",
                    64'({bus.currentPosition, bus.targetPosition, bus.currentPiece, bus.targetPiece}),
                    64'({f, t, sp, tp}));
            end
            if (bus.doneValid === 1'b1) seen = 1'b1;
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("done_latency", 64'(k), 64'(exp_lat));
        chk("done_code", 64'(bus.doneCode), 64'(exp_code));
        chk("done_ok", 64'(bus.doneOk), 64'(exp_code == 3'd0));
        if (exp_code == 3'd0) begin
            ref_board[t] = sp;
            ref_board[f] = 4'h0;
            ref_black = !ref_black;
            if (ref_count < 255) ref_count++;
            chk("write_count", 64'(wr_a.size() - base), 64'd2);
            if (wr_a.size() - base == 2) begin
                chk("write_to", 64'({wr_a[base], wr_d[base]}), 64'({t, sp}));
                chk("write_from", 64'({wr_a[base + 1], wr_d[base + 1]}), 64'({f, 4'h0}));
            end
        end else begin
            chk("write_count", 64'(wr_a.size() - base), 64'd0);
        end
        @(posedge clk);
        #1;
        chk("done_one_cycle", 64'(bus.doneValid), 64'd0);
        chk("ready_after_done", 64'(bus.moveReady), 64'd1);
        chk("black_to_move", 64'(bus.blackToMove), 64'(ref_black));
        chk("move_count", 64'(bus.moveCount), 64'(ref_count));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base, bad_sq, wpos, bpos, nxt;
        logic [5:0] f, t;
        bit ad;
        n_cmp = 0;
        n_bad = 0;
        bus.moveValid = 1'b0;
        bus.fromPos = 6'd0;
        bus.toPos = 6'd0;
        bus.allowDistance = 1'b0;
        tb_we = 1'b0;
        tb_clr = 1'b0;
        tb_wa = 6'd0;
        tb_wd = 4'h0;
        for (int i = 0; i < 64; i++) ref_board[i] = 4'h0;
        ref_black = 1'b0;
        ref_count = 0;

        vecs[0] = '{1'b0, 6'd0,  4'h0, 6'd8,  6'd16, 1'b1, 3'd0};
        vecs[1] = '{1'b0, 6'd0,  4'h0, 6'd20, 6'd20, 1'b1, 3'd1};
        vecs[2] = '{1'b0, 6'd0,  4'h0, 6'd30, 6'd31, 1'b1, 3'd2};
        vecs[3] = '{1'b0, 6'd0,  4'h0, 6'd48, 6'd40, 1'b1, 3'd0};
        vecs[4] = '{1'b0, 6'd0,  4'h0, 6'd40, 6'd32, 1'b1, 3'd3};
        vecs[5] = '{1'b0, 6'd0,  4'h0, 6'd0,  6'd1,  1'b1, 3'd4};
        vecs[6] = '{1'b1, 6'd1,  4'hB, 6'd0,  6'd1,  1'b1, 3'd0};
        vecs[7] = '{1'b1, 6'd50, 4'hF, 6'd50, 6'd42, 1'b1, 3'd2};
        vecs[8] = '{1'b1, 6'd42, 4'hF, 6'd40, 6'd42, 1'b0, 3'd5};
        vecs[9] = '{1'b0, 6'd0,  4'h0, 6'd40, 6'd42, 1'b1, 3'd0};

        tb_clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tb_clr = 1'b0;
        chk("reset_outputs", 64'(out_vec()), 64'({1'b1, 51'd0}));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        poke(6'd8, 4'h1);
        poke(6'd48, 4'h9);
        poke(6'd0, 4'h2);
        poke(6'd1, 4'h3);
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].set_en) poke(vecs[i].set_sq, vecs[i].set_pc);
            do_move(vecs[i].f, vecs[i].t, vecs[i].ad, vecs[i].code);
        end

        // Reset while the first board write is on the bus aborts the move.
        bus.fromPos = 6'd16;
        bus.toPos = 6'd24;
        bus.allowDistance = 1'b1;
        bus.moveValid = 1'b1;
        @(posedge clk);
        #1;
        bus.moveValid = 1'b0;
        n = 0;
        while (bus.boardWe !== 1'b1 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reached_wr_to", 64'(bus.boardWe), 64'd1);
        base = wr_a.size();
        rst_n = 1'b0;
        #1;
        chk("abort_reset_outputs", 64'(out_vec()), 64'({1'b1, 51'd0}));
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_write", 64'(wr_a.size() - base), 64'd0);
        chk("abort_ready", 64'(bus.moveReady), 64'd1);
        rst_n = 1'b1;
        ref_black = 1'b0;
        ref_count = 0;
        @(posedge clk);
        #1;

        for (int r = 0; r < 80; r++) begin
            f = 6'($urandom_range(0, 63));
            t = ($urandom_range(0, 7) == 0) ? f : 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) poke(f, {ref_black, 3'($urandom_range(1, 7))});
            if ($urandom_range(0, 1) != 0) poke(t, 4'($urandom_range(0, 15)));
            ad = ($urandom_range(0, 3) != 0);
            do_move(f, t, ad, ref_code(f, t, ad));
        end
        bad_sq = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_board[i]) bad_sq++;
        chk("board_contents", 64'(bad_sq), 64'd0);

        // Counter saturation: two kings shuffling back and forth.
        rst_n = 1'b0;
        tb_clr = 1'b1;
        @(posedge clk);
        #1;
        tb_clr = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) ref_board[i] = 4'h0;
        ref_black = 1'b0;
        ref_count = 0;
        poke(6'd56, 4'h6);
        poke(6'd63, 4'hE);
        wpos = 56;
        bpos = 63;
        for (int m = 0; m < 258; m++) begin
            if (!ref_black) begin
                nxt = (wpos == 56) ? 57 : 56;
                do_move(6'(wpos), 6'(nxt), 1'b1, 3'd0);
                wpos = nxt;
            end else begin
                nxt = (bpos == 63) ? 62 : 63;
                do_move(6'(bpos), 6'(nxt), 1'b1, 3'd0);
                bpos = nxt;
            end
        end
        chk("move_count_saturated", 64'(bus.moveCount), 64'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Sequences one chess move request through the board RAM and the checkDistance rule block.
- Reads the source and target squares, presents both squares and pieces to checkDistance, and applies turn, ownership and emptiness rules.
- Commits a legal move by writing the board, or rejects it with an error code.
- Sits between the input/cursor logic (requester) and the board memory / checkDistance datapath.

Parameters:
- CHECK_LAT, 1, cycles the checkDistance inputs are held stable before allowDistance is sampled (1..15).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- moveValid  input  1  requester has a move on fromPos/toPos
- moveReady  output  1  sequencer can accept a move (high only in IDLE)
- fromPos  input  6  source square, index = rank*8+file
- toPos  input  6  target square
- boardAddr  output  6  board read address; synchronous read, data valid the following cycle
- boardData  input  4  board read data
- boardWe  output  1  board write enable, one-cycle pulse
- boardWAddr  output  6  board write address
- boardWData  output  4  board write data
- currentPosition  output  6  to checkDistance
- targetPosition  output  6  to checkDistance
- currentPiece  output  4  to checkDistance
- targetPiece  output  4  to checkDistance
- allowDistance  input  1  from checkDistance, combinational
- doneValid  output  1  one-cycle result pulse
- doneOk  output  1  move committed (valid with doneValid)
- doneCode  output  3  result code (valid with doneValid)
- blackToMove  output  1  0 = white to move
- moveCount  output  8  committed moves, saturating

Behaviour:
- Piece encoding:
  - bit3 = colour (0 white, 1 black); bits[2:0] = type.
  - Type 0 = empty; types 1..6 = pawn..king; type 7 is invalid and treated as empty.
  - Empty square written as 4'b0000.
- Reset (async, rst_n low): state IDLE; moveReady=1; boardWe=0; doneValid=0; doneOk=0; doneCode=0; blackToMove=0; moveCount=0; boardAddr, boardWAddr, boardWData, currentPosition, targetPosition, currentPiece, targetPiece all 0.
  - Reset during any state aborts the move: no write, no doneValid.
- States:
  - IDLE: moveReady=1. On moveValid&&moveReady, latch fromPos/toPos, drive boardAddr=fromPos, go to RD_FROM. moveReady is 0 in every other state.
  - RD_FROM: drive boardAddr=toPos; go to RD_TO.
  - RD_TO: capture boardData as fromPiece; go to CAPT.
  - CAPT: capture boardData as toPiece. Load the checkDistance outputs (currentPosition=from, targetPosition=to, currentPiece=fromPiece, targetPiece=toPiece) and hold them until the next accept. Clear the wait counter. Go to CHECK.
  - CHECK: increment the wait counter. When counter==CHECK_LAT, sample allowDistance and evaluate the rules. Legal move goes to WR_TO; illegal move goes to DONE.
  - WR_TO: boardWe=1, boardWAddr=to, boardWData=fromPiece; go to WR_FROM.
  - WR_FROM: boardWe=1, boardWAddr=from, boardWData=0; go to DONE.
  - DONE: doneValid=1 for exactly this cycle. If doneOk, toggle blackToMove and increment moveCount (saturate at 255). Go to IDLE.
- Rule priority (first match wins) -> doneCode:
  - 1: from==to
  - 2: source empty or type 7
  - 3: source colour != blackToMove
  - 4: target non-empty and same colour as source
  - 5: allowDistance==0
  - 0: legal, doneOk=1
- Latency: an accept in cycle N gives doneValid in cycle N+5+CHECK_LAT for a commit and N+3+CHECK_LAT for a reject.
- A new moveValid is ignored until IDLE; a requester holding moveValid high is accepted the cycle after DONE.

Test Plan:
- Reset, then white pawn 4'h1 at square 8; request 8->16 with allowDistance=1 -> doneOk=1, code 0. Writes (16,4'h1) then (8,0). blackToMove=1, moveCount=1.
- Request 20->20 -> doneCode=1, no boardWe pulse, blackToMove unchanged.
- Source square 30 empty -> code 2. Black piece 4'h9 at 48 while white to move -> code 3.
- White rook 4'h2 at 0, white knight 4'h3 at 1, request 0->1 -> code 4 even with allowDistance=1. Same move onto black 4'hB -> commit.
- allowDistance=0 with CHECK_LAT=3 -> code 5, doneValid exactly 6 cycles after accept. Check that currentPosition/targetPosition/currentPiece/targetPiece are held stable throughout CHECK.
- Assert rst_n low during WR_TO -> no second write, outputs at reset values, moveReady=1. 256 legal commits -> moveCount stays 255.
